// File: rtl/hazard_unit_mc_pkg.sv
// rtl/hazard_unit_mc_pkg.sv - shared pipeline constants and types for the hazard unit
package hazard_unit_mc_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  localparam logic [1:0] RES_SRC_LOAD = 2'b01;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// rtl/hazard_unit_mc_if.sv - hazard unit pipeline/bus signal bundle
interface hazard_unit_mc_if #(
  parameter int REG_AW = 5,
  parameter int CNTW   = 32
);
  logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic              loadE, regWriteM, regWriteW, memReqM, dmem_ready, PCSrcE, clr_cnt;
  logic [1:0]        forwardAE, forwardBE;
  logic              stallF, stallD, stallE, stallM;
  logic              flushD, flushE, flushW;
  logic              mem_busy, mem_timeout;
  logic [CNTW-1:0]   stall_cnt, flush_cnt;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output loadE, regWriteM, regWriteW, memReqM, dmem_ready, PCSrcE, clr_cnt,
    input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
    input  flushD, flushE, flushW, mem_busy, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  loadE, regWriteM, regWriteW, memReqM, dmem_ready, PCSrcE, clr_cnt,
    output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
    output flushD, flushE, flushW, mem_busy, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_unit_mc_fwd_sel.sv
// rtl/hazard_unit_mc_fwd_sel.sv - bypass select for one ALU operand, M over W
module hazard_unit_mc_fwd_sel
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        fwd_sel
);

  always_comb begin
    fwd_sel = FWD_NONE;
    if (rs_e != '0 && rs_e == rd_m && reg_write_m) begin
      fwd_sel = FWD_M;
    end else if (rs_e != '0 && rs_e == rd_w && reg_write_w) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - forwarding, stall/flush control, memory-wait watchdog and perf counters
module hazard_unit_mc
  import hazard_unit_mc_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 32
) (
  input logic              CLK,
  input logic              RESET,
  hazard_unit_mc_if.slave  hif
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic            mem_busy_q, mem_busy_d;
  logic            mem_timeout_q, mem_timeout_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;
  logic            lw_stall, mem_stall;
  logic            stall_f, flush_e;

  hazard_unit_mc_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e(hif.rs1E), .rd_m(hif.rdM), .rd_w(hif.rdW),
    .reg_write_m(hif.regWriteM), .reg_write_w(hif.regWriteW),
    .fwd_sel(hif.forwardAE)
  );

  hazard_unit_mc_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e(hif.rs2E), .rd_m(hif.rdM), .rd_w(hif.rdW),
    .reg_write_m(hif.regWriteM), .reg_write_w(hif.regWriteW),
    .fwd_sel(hif.forwardBE)
  );

  // A waiting memory access freezes F..M; branch/load-use effects are held until release.
  always_comb begin
    lw_stall  = hif.loadE && (hif.rdE != '0) && (hif.rdE == hif.rs1D || hif.rdE == hif.rs2D);
    mem_stall = hif.memReqM && !hif.dmem_ready;
    stall_f   = mem_stall | lw_stall;
    flush_e   = !mem_stall && (lw_stall | hif.PCSrcE);

    hif.stallF = stall_f;
    hif.stallD = stall_f;
    hif.stallE = mem_stall;
    hif.stallM = mem_stall;
    hif.flushW = mem_stall;
    hif.flushD = !mem_stall && hif.PCSrcE;
    hif.flushE = flush_e;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mem_stall)  state_d = WAIT;
      WAIT:    if (!mem_stall) state_d = RUN;
      default: state_d = RUN;
    endcase
    mem_busy_d = (state_d == WAIT);

    wait_cnt_d = '0;
    if (mem_stall) begin
      wait_cnt_d = (wait_cnt_q == WCW'(TIMEOUT)) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end
    mem_timeout_d = mem_timeout_q | (mem_stall && wait_cnt_q == WCW'(TIMEOUT - 1));

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hif.clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_f && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush_e && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= RUN;
      mem_busy_q    <= 1'b0;
      mem_timeout_q <= 1'b0;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      mem_busy_q    <= mem_busy_d;
      mem_timeout_q <= mem_timeout_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign hif.mem_busy    = mem_busy_q;
  assign hif.mem_timeout = mem_timeout_q;
  assign hif.stall_cnt   = stall_cnt_q;
  assign hif.flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - directed scoreboard bench for hazard_unit_mc
module tb_hazard_unit_mc;

  localparam int S_FA = 0, S_FB = 1, S_SF = 2, S_SD = 3, S_SE = 4, S_SM = 5, S_FD = 6;
  localparam int S_FE = 7, S_FW = 8, S_BUSY = 9, S_TO = 10, S_SCNT = 11, S_FCNT = 12;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_unit_mc_if #(.REG_AW(5), .CNTW(3)) hif ();

  hazard_unit_mc #(.REG_AW(5), .TIMEOUT(4), .CNTW(3)) dut (
    .CLK  (clk),
    .RESET(rst),
    .hif  (hif)
  );

  function automatic logic [31:0] obs(int s);
    case (s)
      S_FA:    return {30'd0, hif.forwardAE};
      S_FB:    return {30'd0, hif.forwardBE};
      S_SF:    return {31'd0, hif.stallF};
      S_SD:    return {31'd0, hif.stallD};
      S_SE:    return {31'd0, hif.stallE};
      S_SM:    return {31'd0, hif.stallM};
      S_FD:    return {31'd0, hif.flushD};
      S_FE:    return {31'd0, hif.flushE};
      S_FW:    return {31'd0, hif.flushW};
      S_BUSY:  return {31'd0, hif.mem_busy};
      S_TO:    return {31'd0, hif.mem_timeout};
      S_SCNT:  return {29'd0, hif.stall_cnt};
      S_FCNT:  return {29'd0, hif.flush_cnt};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic push_pipe(input string tag, input logic sf, input logic sd, input logic se,
                           input logic sm, input logic fd, input logic fe, input logic fw);
    push_exp({tag, ".stallF"}, S_SF, {31'd0, sf});
    push_exp({tag, ".stallD"}, S_SD, {31'd0, sd});
    push_exp({tag, ".stallE"}, S_SE, {31'd0, se});
    push_exp({tag, ".stallM"}, S_SM, {31'd0, sm});
    push_exp({tag, ".flushD"}, S_FD, {31'd0, fd});
    push_exp({tag, ".flushE"}, S_FE, {31'd0, fe});
    push_exp({tag, ".flushW"}, S_FW, {31'd0, fw});
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [31:0] o;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sig);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    hif.rs1D = '0; hif.rs2D = '0; hif.rs1E = '0; hif.rs2E = '0;
    hif.rdE = '0; hif.rdM = '0; hif.rdW = '0;
    hif.loadE = 1'b0; hif.regWriteM = 1'b0; hif.regWriteW = 1'b0;
    hif.memReqM = 1'b0; hif.dmem_ready = 1'b0; hif.PCSrcE = 1'b0; hif.clr_cnt = 1'b0;

    // reset state; combinational outputs still follow inputs during reset
    step(); step();
    hif.memReqM = 1'b1;
    push_exp("rst.busy", S_BUSY, 0);
    push_exp("rst.timeout", S_TO, 0);
    push_exp("rst.stall_cnt", S_SCNT, 0);
    push_exp("rst.flush_cnt", S_FCNT, 0);
    push_exp("rst.comb_stallF", S_SF, 1);
    check_sb();
    step();
    rst = 1'b0; hif.memReqM = 1'b0;
    step();

    // forwarding
    hif.rs1E = 5; hif.rs2E = 5; hif.rdM = 5; hif.rdW = 5;
    hif.regWriteM = 1'b1; hif.regWriteW = 1'b1;
    push_exp("fwd.a_m_prio", S_FA, 2);
    push_exp("fwd.b_m_prio", S_FB, 2);
    check_sb();
    hif.regWriteM = 1'b0;
    push_exp("fwd.a_w", S_FA, 1);
    check_sb();
    hif.rs1E = 0; hif.rdM = 0; hif.regWriteM = 1'b1; hif.rs2E = 3; hif.rdW = 3;
    push_exp("fwd.a_x0", S_FA, 0);
    push_exp("fwd.b_w", S_FB, 1);
    check_sb();
    hif.rs2E = 0; hif.rdW = 0; hif.regWriteM = 1'b0; hif.regWriteW = 1'b0;

    // load-use stall
    hif.loadE = 1'b1; hif.rdE = 7; hif.rs2D = 7;
    push_pipe("lw", 1, 1, 0, 0, 0, 1, 0);
    check_sb();
    step();
    hif.loadE = 1'b0;
    push_pipe("lw_clear", 0, 0, 0, 0, 0, 0, 0);
    check_sb();
    hif.loadE = 1'b1; hif.rdE = 0; hif.rs2D = 0;
    push_exp("lw_x0.stallF", S_SF, 0);
    push_exp("lw_x0.flushE", S_FE, 0);
    check_sb();
    hif.loadE = 1'b0;

    // three-cycle memory wait
    hif.clr_cnt = 1'b1; step(); hif.clr_cnt = 1'b0;
    hif.memReqM = 1'b1; hif.dmem_ready = 1'b0;
    push_pipe("mw.c1", 1, 1, 1, 1, 0, 0, 1);
    push_exp("mw.c1.busy", S_BUSY, 0);
    check_sb();
    step();
    push_pipe("mw.c2", 1, 1, 1, 1, 0, 0, 1);
    push_exp("mw.c2.busy", S_BUSY, 1);
    check_sb();
    step();
    push_exp("mw.c3.busy", S_BUSY, 1);
    push_exp("mw.c3.stallM", S_SM, 1);
    check_sb();
    step();
    hif.dmem_ready = 1'b1;
    push_pipe("mw.c4", 0, 0, 0, 0, 0, 0, 0);
    push_exp("mw.c4.busy", S_BUSY, 1);
    check_sb();
    step();
    hif.memReqM = 1'b0;
    push_exp("mw.end.busy", S_BUSY, 0);
    push_exp("mw.stall_cnt", S_SCNT, 3);
    push_exp("mw.flush_cnt", S_FCNT, 0);
    check_sb();

    // branch held during memory wait
    hif.memReqM = 1'b1; hif.dmem_ready = 1'b0; hif.PCSrcE = 1'b1;
    push_pipe("br.wait1", 1, 1, 1, 1, 0, 0, 1);
    check_sb();
    step();
    push_pipe("br.wait2", 1, 1, 1, 1, 0, 0, 1);
    check_sb();
    step();
    hif.dmem_ready = 1'b1;
    push_pipe("br.release", 0, 0, 0, 0, 1, 1, 0);
    check_sb();
    step();
    hif.memReqM = 1'b0; hif.PCSrcE = 1'b0;
    push_exp("br.flush_cnt", S_FCNT, 1);
    push_exp("br.stall_cnt", S_SCNT, 5);
    check_sb();

    // watchdog
    hif.clr_cnt = 1'b1; step(); hif.clr_cnt = 1'b0;
    hif.memReqM = 1'b1; hif.dmem_ready = 1'b0;
    step(); step(); step();
    push_exp("wd.after3", S_TO, 0);
    check_sb();
    step();
    push_exp("wd.after4", S_TO, 1);
    push_exp("wd.busy", S_BUSY, 1);
    check_sb();
    hif.dmem_ready = 1'b1;
    step();
    push_exp("wd.after_ready", S_TO, 1);
    push_exp("wd.ready_busy", S_BUSY, 0);
    check_sb();
    hif.memReqM = 1'b0; hif.clr_cnt = 1'b1;
    step();
    hif.clr_cnt = 1'b0;
    push_exp("wd.after_clr", S_TO, 1);
    push_exp("wd.clr_stall_cnt", S_SCNT, 0);
    check_sb();
    hif.memReqM = 1'b1; hif.dmem_ready = 1'b0;
    step();
    push_exp("wd.rewait_busy", S_BUSY, 1);
    check_sb();
    rst = 1'b1;
    step();
    push_exp("wd.rst_busy", S_BUSY, 0);
    push_exp("wd.rst_timeout", S_TO, 0);
    push_exp("wd.rst_stall_cnt", S_SCNT, 0);
    check_sb();
    rst = 1'b0; hif.memReqM = 1'b0;
    step();
    push_exp("wd.post_rst_busy", S_BUSY, 0);
    check_sb();

    // counter saturation and clear priority
    hif.loadE = 1'b1; hif.rdE = 7; hif.rs1D = 7;
    repeat (7) step();
    push_exp("sat.at7", S_SCNT, 7);
    check_sb();
    repeat (2) step();
    push_exp("sat.hold", S_SCNT, 7);
    push_exp("sat.flush", S_FCNT, 7);
    check_sb();
    hif.clr_cnt = 1'b1;
    step();
    hif.clr_cnt = 1'b0;
    push_exp("sat.clr_prio", S_SCNT, 0);
    push_exp("sat.clr_flush", S_FCNT, 0);
    check_sb();
    step();
    push_exp("sat.resume", S_SCNT, 1);
    check_sb();
    hif.loadE = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
